// File: rtl/imm_builder_pkg.sv
// Shared definitions for the immediate builder.
//   IMM_REG_DW    default width of the assembled immediate
//   IMM_FIELD_DW  default width of one immediate field
//   imm_state_e   FSM state encoding (IDLE / ACCUM / DONE)
package imm_builder_pkg;

  localparam int IMM_REG_DW   = 16;
  localparam int IMM_FIELD_DW = 4;

  typedef enum logic [1:0] {
    IMM_IDLE  = 2'd0,
    IMM_ACCUM = 2'd1,
    IMM_DONE  = 2'd2
  } imm_state_e;

  // Width needed to hold a field count of 0..max_fields.
  function automatic int imm_cnt_w(input int max_fields);
    return $clog2(max_fields + 1);
  endfunction

  // Width of the "fields used minus one" output.
  function automatic int imm_fld_w(input int max_fields);
    return (max_fields > 1) ? $clog2(max_fields) : 1;
  endfunction

endpackage

// File: rtl/imm_builder_if.sv
// Field-in / immediate-out handshake bundle for imm_builder.
//   in_valid/in_field/in_last/in_zext  upstream field slot (master drives)
//   in_ready                           builder accepts a field
//   out_valid/out_data/out_fields      assembled immediate (slave drives)
//   out_ready                          consumer takes the immediate
interface imm_builder_if #(
  parameter int REG_DATA_WIDTH = imm_builder_pkg::IMM_REG_DW,
  parameter int DATA_2_WIDTH   = imm_builder_pkg::IMM_FIELD_DW
) ();
  localparam int MAX_FIELDS = REG_DATA_WIDTH / DATA_2_WIDTH;
  localparam int FLD_W      = imm_builder_pkg::imm_fld_w(MAX_FIELDS);

  logic                      in_valid;
  logic [DATA_2_WIDTH-1:0]   in_field;
  logic                      in_last;
  logic                      in_zext;
  logic                      in_ready;
  logic                      out_valid;
  logic [REG_DATA_WIDTH-1:0] out_data;
  logic [FLD_W-1:0]          out_fields;
  logic                      out_ready;

  modport master (
    output in_valid, in_field, in_last, in_zext, out_ready,
    input  in_ready, out_valid, out_data, out_fields
  );

  modport slave (
    input  in_valid, in_field, in_last, in_zext, out_ready,
    output in_ready, out_valid, out_data, out_fields
  );
endinterface

// File: rtl/imm_var_extend.sv
// Variable-width sign/zero extension of an accumulated immediate.
//   acc   accumulator, fields right-aligned (last field in the LSBs)
//   cnt   number of valid fields (1..MAX_FIELDS); 0 gives all-zero
//   zext  1 = zero-extend, 0 = sign-extend from bit cnt*DATA_2_WIDTH-1
//   ext   extended word
// Purely combinational.
module imm_var_extend
  import imm_builder_pkg::*;
#(
  parameter int REG_DATA_WIDTH = IMM_REG_DW,
  parameter int DATA_2_WIDTH   = IMM_FIELD_DW,
  localparam int MAX_FIELDS    = REG_DATA_WIDTH / DATA_2_WIDTH,
  localparam int CNT_W         = imm_cnt_w(MAX_FIELDS)
) (
  input  logic [REG_DATA_WIDTH-1:0] acc,
  input  logic [CNT_W-1:0]          cnt,
  input  logic                      zext,
  output logic [REG_DATA_WIDTH-1:0] ext
);

  // One candidate per possible field count, then a mux on cnt.
  logic [MAX_FIELDS:0][REG_DATA_WIDTH-1:0] cand;

  assign cand[0] = '0;

  for (genvar k = 1; k <= MAX_FIELDS; k++) begin : g_w
    localparam int W = k * DATA_2_WIDTH;
    if (W == REG_DATA_WIDTH) begin : g_full
      assign cand[k] = acc;
    end else begin : g_part
      assign cand[k] = {{(REG_DATA_WIDTH-W){~zext & acc[W-1]}}, acc[W-1:0]};
    end
  end

  always_comb begin
    ext = '0;
    for (int k = 1; k <= MAX_FIELDS; k++)
      if (cnt == CNT_W'(k)) ext = cand[k];
  end

endmodule

// File: rtl/imm_builder.sv
// Sequential immediate assembler.
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   imm_builder_if slave: fields in (MS field first), extended
//         immediate out with fields-used-minus-one, valid/ready on both.
// Fields shift into an accumulator; on the last (or MAX_FIELDS-th) field
// the extended word is registered and held until the consumer takes it.
module imm_builder
  import imm_builder_pkg::*;
#(
  parameter int REG_DATA_WIDTH = IMM_REG_DW,
  parameter int DATA_2_WIDTH   = IMM_FIELD_DW
) (
  input  logic         clk,
  input  logic         rst,
  imm_builder_if.slave bus
);

  localparam int MAX_FIELDS = REG_DATA_WIDTH / DATA_2_WIDTH;
  localparam int CNT_W      = imm_cnt_w(MAX_FIELDS);
  localparam int FLD_W      = imm_fld_w(MAX_FIELDS);

  imm_state_e                state_q, state_d;
  logic [REG_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      zext_q, zext_d;
  logic                      out_valid_q, out_valid_d;
  logic [REG_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [FLD_W-1:0]          out_fields_q, out_fields_d;

  // in_ready depends only on state (and is held low while in reset).
  logic in_ready;
  assign in_ready = rst & (state_q != IMM_DONE);

  logic accept;
  assign accept = bus.in_valid & in_ready;

  // Values the accumulator takes if this cycle's field is accepted.
  // A first field starts fresh; later fields shift in below the old ones.
  logic                      first;
  logic [REG_DATA_WIDTH-1:0] acc_nx;
  logic [CNT_W-1:0]          cnt_nx;
  logic                      zext_nx;
  logic                      fin;

  assign first   = (state_q == IMM_IDLE);
  assign acc_nx  = first ? REG_DATA_WIDTH'(bus.in_field)
                         : REG_DATA_WIDTH'({acc_q, bus.in_field});
  assign cnt_nx  = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign zext_nx = first ? bus.in_zext : zext_q;
  // A full accumulator completes regardless of in_last.
  assign fin     = bus.in_last | (cnt_nx == CNT_W'(MAX_FIELDS));

  // Extend the post-accept value so the result registers on the same
  // edge that takes the final field.
  logic [REG_DATA_WIDTH-1:0] ext_word;

  imm_var_extend #(
    .REG_DATA_WIDTH (REG_DATA_WIDTH),
    .DATA_2_WIDTH   (DATA_2_WIDTH)
  ) u_ext (
    .acc  (acc_nx),
    .cnt  (cnt_nx),
    .zext (zext_nx),
    .ext  (ext_word)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    zext_d       = zext_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_fields_d = out_fields_q;
    unique case (state_q)
      IMM_IDLE, IMM_ACCUM: begin
        if (accept) begin
          acc_d  = acc_nx;
          cnt_d  = cnt_nx;
          zext_d = zext_nx;
          if (fin) begin
            state_d      = IMM_DONE;
            out_valid_d  = 1'b1;
            out_data_d   = ext_word;
            out_fields_d = FLD_W'(cnt_nx - CNT_W'(1));
          end else begin
            state_d = IMM_ACCUM;
          end
        end
      end
      IMM_DONE: begin
        if (bus.out_ready) begin
          state_d      = IMM_IDLE;
          acc_d        = '0;
          cnt_d        = '0;
          zext_d       = 1'b0;
          out_valid_d  = 1'b0;
          out_data_d   = '0;
          out_fields_d = '0;
        end
      end
      default: state_d = IMM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IMM_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      zext_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_fields_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      zext_q       <= zext_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_fields_q <= out_fields_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_fields = out_fields_q;

endmodule
